// File: rtl/branch_predictor_gshare.sv
// Gshare branch predictor: direct-mapped BTB for targets, a table of 2-bit
// saturating counters indexed by PC XOR global history, and mispredict
// detection / performance counters for branches resolved in EX.
module branch_predictor_gshare #(
    parameter int unsigned BTB_DEPTH = 64,
    parameter int unsigned PHT_DEPTH = 256,
    parameter int unsigned GHR_W     = 8,
    localparam int unsigned BTB_AW   = $clog2(BTB_DEPTH),
    localparam int unsigned PHT_AW   = $clog2(PHT_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       PCF,
    output logic              pred_taken,
    output logic [31:0]       pred_target,
    output logic              pred_hit,
    output logic [PHT_AW-1:0] pred_idx,
    input  logic              upd_valid,
    input  logic [31:0]       upd_pc,
    input  logic [PHT_AW-1:0] upd_idx,
    input  logic              upd_taken,
    input  logic [31:0]       upd_target,
    input  logic              upd_pred_taken,
    input  logic [31:0]       upd_pred_target,
    output logic              mispredict,
    output logic [31:0]       stat_branches,
    output logic [31:0]       stat_mispred
);

    localparam int unsigned TAG_W = 30 - BTB_AW;

    logic [BTB_DEPTH-1:0] btbValid;
    logic [TAG_W-1:0]     btbTag    [BTB_DEPTH];
    logic [31:0]          btbTarget [BTB_DEPTH];
    logic [1:0]           pht       [PHT_DEPTH];
    logic [GHR_W-1:0]     ghr;

    logic [BTB_AW-1:0] lookIdx;
    logic [TAG_W-1:0]  lookTag;
    logic [BTB_AW-1:0] updBtbIdx;
    logic [TAG_W-1:0]  updTag;
    logic [1:0]        phtCur;
    logic [1:0]        phtNext;
    logic [GHR_W-1:0]  ghrNext;
    logic              unusedBits;

    assign lookIdx   = PCF[BTB_AW+1:2];
    assign lookTag   = PCF[31:BTB_AW+2];
    assign updBtbIdx = upd_pc[BTB_AW+1:2];
    assign updTag    = upd_pc[31:BTB_AW+2];
    // Word-aligned PCs: the byte-offset bits never take part in lookup.
    assign unusedBits = ^{PCF[1:0], upd_pc[1:0]};

    // Fetch-stage lookup: purely combinational on PCF and current state.
    always_comb begin
        pred_idx    = PCF[PHT_AW+1:2] ^ PHT_AW'(ghr);
        pred_hit    = btbValid[lookIdx] && (btbTag[lookIdx] == lookTag);
        pred_taken  = pred_hit && pht[pred_idx][1];
        pred_target = pred_taken ? btbTarget[lookIdx] : PCF + 32'd4;
    end

    // EX-stage resolution: redirect request and next counter / history values.
    always_comb begin
        mispredict = upd_valid && ((upd_taken != upd_pred_taken) ||
                                   (upd_taken && (upd_target != upd_pred_target)));
        phtCur  = pht[upd_idx];
        phtNext = phtCur;
        if (upd_taken && phtCur != 2'b11) begin
            phtNext = phtCur + 2'b01;
        end else if (!upd_taken && phtCur != 2'b00) begin
            phtNext = phtCur - 2'b01;
        end
        ghrNext = (ghr << 1) | GHR_W'(upd_taken);
    end

    // Resettable state: valid bits, counters, history and statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btbValid      <= '0;
            ghr           <= '0;
            stat_branches <= '0;
            stat_mispred  <= '0;
            for (int i = 0; i < int'(PHT_DEPTH); i++) begin
                pht[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            pht[upd_idx] <= phtNext;
            ghr          <= ghrNext;
            if (stat_branches != 32'hFFFF_FFFF) begin
                stat_branches <= stat_branches + 32'd1;
            end
            if (mispredict && stat_mispred != 32'hFFFF_FFFF) begin
                stat_mispred <= stat_mispred + 32'd1;
            end
            if (upd_taken) begin
                btbValid[updBtbIdx] <= 1'b1;
            end
        end
    end

    // BTB payload needs no reset; a cleared valid bit hides stale contents.
    always_ff @(posedge clk) begin
        if (rst && upd_valid && upd_taken) begin
            btbTag[updBtbIdx]    <= updTag;
            btbTarget[updBtbIdx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed bench for branch_predictor_gshare: a default-sized instance and a
// small instance (16-entry BTB, 64-entry PHT, 6-bit history) share stimulus.
module tb_branch_predictor_gshare;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [7:0]  upd_idx;
    logic [5:0]  upd_idx2;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        pred_taken, pred_hit, mispredict;
    logic [31:0] pred_target, stat_branches, stat_mispred;
    logic [7:0]  pred_idx;
    logic        pred_taken2, pred_hit2, mispredict2;
    logic [31:0] pred_target2, stat_branches2, stat_mispred2;
    logic [5:0]  pred_idx2;

    int checks   = 0;
    int failures = 0;
    int expBranches = 0;
    int expMispred  = 0;
    logic pendMis;

    always #5 clk = ~clk;

    branch_predictor_gshare dut (
        .clk(clk), .rst(rst), .PCF(PCF),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit),
        .pred_idx(pred_idx),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    branch_predictor_gshare #(.BTB_DEPTH(16), .PHT_DEPTH(64), .GHR_W(6)) dutSmall (
        .clk(clk), .rst(rst), .PCF(PCF),
        .pred_taken(pred_taken2), .pred_target(pred_target2), .pred_hit(pred_hit2),
        .pred_idx(pred_idx2),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_idx(upd_idx2), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target),
        .mispredict(mispredict2), .stat_branches(stat_branches2), .stat_mispred(stat_mispred2)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic hit, input logic tk,
                        input logic [31:0] tgt);
        PCF = pc;
        #1;
        checkVal("pred_hit", 32'(pred_hit), 32'(hit));
        checkVal("pred_taken", 32'(pred_taken), 32'(tk));
        checkVal("pred_target", pred_target, tgt);
    endtask

    task automatic look2(input logic [31:0] pc, input logic hit, input logic tk,
                         input logic [31:0] tgt);
        PCF = pc;
        #1;
        checkVal("small_pred_hit", 32'(pred_hit2), 32'(hit));
        checkVal("small_pred_taken", 32'(pred_taken2), 32'(tk));
        checkVal("small_pred_target", pred_target2, tgt);
    endtask

    task automatic checkStats();
        checkVal("stat_branches", stat_branches, 32'(expBranches));
        checkVal("stat_mispred", stat_mispred, 32'(expMispred));
        checkVal("small_stat_branches", stat_branches2, 32'(expBranches));
        checkVal("small_stat_mispred", stat_mispred2, 32'(expMispred));
    endtask

    task automatic updDrive(input logic [31:0] pc, input logic [7:0] idx, input logic tk,
                            input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                            input logic expMis);
        @(negedge clk);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_idx         = idx;
        upd_idx2        = idx[5:0];
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
        pendMis         = expMis;
        #1;
        checkVal("mispredict", 32'(mispredict), 32'(expMis));
        checkVal("small_mispredict", 32'(mispredict2), 32'(expMis));
    endtask

    task automatic updCommit();
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        expBranches++;
        if (pendMis) expMispred++;
    endtask

    task automatic update(input logic [31:0] pc, input logic [7:0] idx, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                          input logic expMis);
        updDrive(pc, idx, tk, tgt, ptk, ptgt, expMis);
        updCommit();
    endtask

    // Not-taken updates on an unrelated entry shift zeros into the history.
    task automatic flushHistory(input int n);
        for (int i = 0; i < n; i++) begin
            update(32'h3FC, 8'h3F, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b0; PCF = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_idx = '0;
        upd_idx2 = '0; upd_taken = 1'b0; upd_target = '0; upd_pred_taken = 1'b0;
        upd_pred_target = '0; pendMis = 1'b0;

        // During reset
        #2;
        look(32'h100, 1'b0, 1'b0, 32'h104);
        upd_valid = 1'b1; upd_taken = 1'b1; upd_target = 32'h80;
        #1;
        checkVal("mispredict_in_reset", 32'(mispredict), 32'd1);
        upd_valid = 1'b0; upd_taken = 1'b0;
        #1;
        checkVal("mispredict_idle", 32'(mispredict), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // Post-reset lookup
        look(32'h100, 1'b0, 1'b0, 32'h104);
        checkVal("pred_idx_reset", 32'(pred_idx), 32'h40);
        checkStats();

        // First taken update; lookup in the same cycle still sees old BTB
        updDrive(32'h100, 8'h40, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1);
        look(32'h100, 1'b0, 1'b0, 32'h104);
        updCommit();
        #1;
        checkVal("pred_idx_ghr1", 32'(pred_idx), 32'h41);
        checkStats();
        look(32'h100, 1'b1, 1'b0, 32'h104);

        // History back to zero: PHT[0x40] is 2
        flushHistory(8);
        look(32'h100, 1'b1, 1'b1, 32'h80);
        update(32'h100, 8'h40, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        look(32'h100, 1'b1, 1'b0, 32'h104);

        // Train to saturation with correct predictions
        for (int i = 0; i < 4; i++) begin
            update(32'h100, 8'h40, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        end
        checkStats();
        flushHistory(8);
        look(32'h100, 1'b1, 1'b1, 32'h80);
        update(32'h100, 8'h40, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        look(32'h100, 1'b1, 1'b1, 32'h80);

        // Alias: 0x200 shares BTB index 0 with 0x100
        update(32'h200, 8'h80, 1'b1, 32'h300, 1'b0, 32'h204, 1'b1);
        look(32'h100, 1'b0, 1'b0, 32'h104);
        look(32'h200, 1'b1, 1'b0, 32'h204);
        checkVal("pred_idx_alias", 32'(pred_idx), 32'h81);

        // Predicted taken but wrong target
        update(32'h200, 8'h80, 1'b1, 32'h300, 1'b1, 32'h304, 1'b1);
        checkStats();

        // upd_valid=0 must leave state alone
        @(negedge clk);
        upd_pc = 32'h100; upd_idx = 8'h40; upd_idx2 = 6'h0; upd_taken = 1'b1;
        upd_target = 32'h999; upd_pred_taken = 1'b0;
        #1;
        checkVal("mispredict_invalid", 32'(mispredict), 32'd0);
        @(posedge clk); #1;
        checkStats();
        look(32'h100, 1'b0, 1'b0, 32'h104);

        // Asynchronous reset between edges, with an update pending
        PCF = 32'h200;
        @(negedge clk);
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h80;
        upd_pred_taken = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checkVal("async_hit", 32'(pred_hit), 32'd0);
        checkVal("async_taken", 32'(pred_taken), 32'd0);
        checkVal("async_target", pred_target, 32'h204);
        checkVal("async_mispredict", 32'(mispredict), 32'd1);
        expBranches = 0; expMispred = 0;
        checkStats();
        @(posedge clk); #1;
        upd_valid = 1'b0;
        rst = 1'b1;
        look(32'h100, 1'b0, 1'b0, 32'h104);
        checkVal("pred_idx_after_reset", 32'(pred_idx), 32'h40);
        checkStats();

        // Small instance
        look2(32'h100, 1'b0, 1'b0, 32'h104);
        checkVal("small_pred_idx_reset", 32'(pred_idx2), 32'h00);
        update(32'h100, 8'h00, 1'b1, 32'h80, 1'b0, 32'h104, 1'b1);
        #1;
        checkVal("small_pred_idx_ghr1", 32'(pred_idx2), 32'h01);
        checkStats();
        flushHistory(6);
        look2(32'h100, 1'b1, 1'b1, 32'h80);
        update(32'h140, 8'h10, 1'b1, 32'h500, 1'b0, 32'h144, 1'b1);
        look2(32'h100, 1'b0, 1'b0, 32'h104);
        look2(32'h140, 1'b1, 1'b0, 32'h144);
        // 0x140 maps to a different entry in the 64-entry BTB
        PCF = 32'h100;
        #1;
        checkVal("default_no_alias_hit", 32'(pred_hit), 32'd1);
        checkStats();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 SHALL provide parameter BTB_DEPTH, default 64, number of BTB entries (power of 2, 4..1024).
REQ-002 SHALL provide parameter PHT_DEPTH, default 256, number of 2-bit pattern-history counters (power of 2, 4..4096).
REQ-003 SHALL provide parameter GHR_W, default 8, global history length (1..log2(PHT_DEPTH)).
REQ-004 SHALL derive BTB_AW=log2(BTB_DEPTH) and PHT_AW=log2(PHT_DEPTH) as local parameters.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 PCF  in  32  fetch-stage PC being looked up.
REQ-008 pred_taken  out  1  predicted taken for PCF.
REQ-009 pred_target  out  32  predicted next PC for PCF.
REQ-010 pred_hit  out  1  BTB hit for PCF.
REQ-011 pred_idx  out  PHT_AW  PHT index used for this lookup; pipeline carries it to EX.
REQ-012 upd_valid  in  1  EX-stage conditional branch resolved this cycle.
REQ-013 upd_pc  in  32  PC of resolved branch (PCE).
REQ-014 upd_idx  in  PHT_AW  pred_idx carried with the branch.
REQ-015 upd_taken  in  1  actual outcome (BranchE).
REQ-016 upd_target  in  32  actual taken target (BrNPC).
REQ-017 upd_pred_taken  in  1, upd_pred_target  in  32  prediction carried with the branch.
REQ-018 mispredict  out  1  EX-stage redirect request.
REQ-019 stat_branches  out  32, stat_mispred  out  32  performance counters.

Function
REQ-020 Lookup SHALL be combinational on PCF: BTB index PCF[BTB_AW+1:2], tag PCF[31:BTB_AW+2].
REQ-021 pred_hit SHALL be 1 iff the indexed entry is valid and its stored tag equals the PCF tag.
REQ-022 pred_idx SHALL equal PCF[PHT_AW+1:2] XOR {zero-extended GHR} (GHR in low bits).
REQ-023 pred_taken SHALL be pred_hit AND PHT[pred_idx][1].
REQ-024 pred_target SHALL be the BTB target when pred_taken=1, else PCF+4 (mod 2^32).
REQ-025 On a rising edge with upd_valid=1, PHT[upd_idx] SHALL increment if upd_taken=1 and decrement otherwise, saturating at 3 and 0.
REQ-026 On upd_valid=1 and upd_taken=1, the BTB entry at upd_pc[BTB_AW+1:2] SHALL be written: valid=1, tag=upd_pc[31:BTB_AW+2], target=upd_target (replacing any aliasing entry).
REQ-027 On upd_valid=1 and upd_taken=0, the BTB SHALL be left unchanged.
REQ-028 On upd_valid=1, GHR SHALL become {GHR[GHR_W-2:0], upd_taken}; otherwise GHR SHALL hold.
REQ-029 mispredict SHALL be combinational: upd_valid AND ((upd_taken != upd_pred_taken) OR (upd_taken AND upd_target != upd_pred_target)); 0 when upd_valid=0.
REQ-030 A lookup and update of the same entry in the same cycle SHALL return the pre-update value; the update becomes visible the following cycle.
REQ-031 stat_branches SHALL increment on each edge with upd_valid=1; stat_mispred SHALL increment on each edge with mispredict=1; both SHALL saturate at 32'hFFFF_FFFF.
REQ-032 Inputs with upd_valid=0 SHALL cause no state change.

Reset
REQ-033 rst=0 SHALL asynchronously clear all BTB valid bits, set every PHT counter to 2'b01 (weakly not-taken), clear GHR, and clear both stat counters.
REQ-034 During and immediately after reset, pred_hit=0, pred_taken=0, pred_target=PCF+4, mispredict=upd_valid-driven only.
REQ-035 Reset asserted mid-operation SHALL discard all learned state with no partial update on the coincident edge.

Verification
REQ-036 After reset, PCF=0x0000_0100 -> pred_hit=0, pred_taken=0, pred_target=0x0000_0104, pred_idx=0x40.
REQ-037 Update pc=0x100, idx=0x40, taken=1, target=0x80, pred_taken=0 -> mispredict=1 that cycle; next cycle GHR=0x01, stat_branches=1, stat_mispred=1, PHT[0x40]=2.
REQ-038 Repeat taken at pc=0x100 with GHR driven back to a constant history four times -> PHT entry saturates at 3; further taken keeps 3; lookup at 0x100 with matching idx gives pred_taken=1, pred_target=0x80.
REQ-039 Alias test (defaults): taken update at 0x100 then at 0x200 (same BTB index, different tag) -> lookup 0x100 pred_hit=0, lookup 0x200 pred_hit=1.
REQ-040 Correct prediction (pred_taken=1, target match, taken=1) -> mispredict=0, stat_mispred unchanged; taken with target mismatch -> mispredict=1.
REQ-041 Assert rst=0 asynchronously between edges after training -> outputs return to REQ-034 values immediately; rerun with BTB_DEPTH=16, PHT_DEPTH=64, GHR_W=6 to confirm parametrisation.
